cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
Synthesizable run controller and output logger for sc1_cpu. It generates the CPU reset sequence, runs the CPU for a bounded number of ticks, and records every change on a watched output port. Each record holds the new value and a timestamp and is stored in a FIFO. It sits between the system clock/reset and an sc1_cpu instance, so a bring-up run works on silicon without a simulator.

Parameters:
DATA_WIDTH, 32, width of watched port and logged value
TS_WIDTH, 32, width of tick counter and timestamps
FIFO_DEPTH_BITS, 4, log FIFO holds 2**FIFO_DEPTH_BITS entries
RESET_CYCLES, 2, cycles cpu_reset is held in RESET state (must be >= 1)
MAX_TICKS, 4000, run length limit in cycles; 0 = unlimited

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new run
stop  in  1  end current run early
cpu_reset  out  1  reset to sc1_cpu
running  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  last run ended by MAX_TICKS
watch_data  in  DATA_WIDTH  monitored CPU port (port_out)
log_rd  in  1  pop head entry
log_valid  out  1  FIFO not empty
log_value  out  DATA_WIDTH  head entry value
log_time  out  TS_WIDTH  head entry timestamp
log_count  out  FIFO_DEPTH_BITS+1  entries stored
log_overflow  out  1  sticky: an entry was dropped
tick_count  out  TS_WIDTH  cycles elapsed in RUN

Behaviour:
- Reset is synchronous and active-high; there is one clock domain (clk).
- Reset values: state IDLE, cpu_reset=1, running=0, done=0, timeout=0, tick_count=0, log_valid=0, log_count=0, log_overflow=0, log_value=0, log_time=0.
- States are IDLE, RESET, RUN and DONE.
  - cpu_reset=1 in IDLE, RESET and DONE; cpu_reset=0 only in RUN.
- IDLE/DONE + start -> RESET.
  - The same edge clears the FIFO, tick_count, timeout and log_overflow.
  - start in RESET or RUN is ignored.
- RESET lasts exactly RESET_CYCLES cycles, then -> RUN.
- RUN:
  - tick_count is 0 in the first RUN cycle and increments by 1 each RUN cycle.
  - stop=1 -> DONE with timeout=0.
  - If MAX_TICKS!=0 and tick_count==MAX_TICKS-1 -> DONE with timeout=1.
  - If both conditions hold in the same cycle, timeout=1.
  - stop outside RUN is ignored.
- DONE: tick_count, timeout and the FIFO contents hold; the block waits for start.
- Logging (RUN only):
  - In the first RUN cycle, watch_data is logged unconditionally.
  - In later RUN cycles, it is logged when watch_data differs from the previous RUN-cycle sample (registered).
  - Each entry is {watch_data, tick_count} of the sampling cycle.
  - The entry is visible at the FIFO head on the cycle after the sampling edge.
- FIFO:
  - First-word-fall-through: log_value/log_time show the head whenever log_valid=1.
  - log_rd with log_valid=1 pops at the clock edge; log_rd with log_valid=0 is ignored.
  - Push when full and no pop: the entry is dropped, log_overflow=1 (sticky until start or reset), log_count stays 2**FIFO_DEPTH_BITS.
  - Push and pop in the same cycle when full: both take effect, log_count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push is stored; the pop is ignored.
  - Reads are allowed in every state; the FIFO is cleared only by start or reset.
- Pointers are FIFO_DEPTH_BITS wide and wrap modulo depth.
- tick_count wraps modulo 2**TS_WIDTH when MAX_TICKS=0.
- Reset mid-run returns everything to reset values immediately (next edge); a run needs a new start.

Test Plan:
- Reset sequence: RESET_CYCLES=2, start pulse in IDLE -> cpu_reset stays 1 for 2 cycles after the start edge, then 0 with running=1 and tick_count=0.
- Change detection: watch_data=5 for 10 RUN cycles, then 6, constant afterwards -> exactly 2 entries, (5,0) then (6,10); log_count=2.
- Timeout: MAX_TICKS=20, no stop -> DONE after tick 19, timeout=1, done=1, cpu_reset=1, tick_count=19.
- Early stop: stop pulse at tick 7 with MAX_TICKS=4000 -> DONE, timeout=0, tick_count=7.
- Overflow: depth 16, watch_data changes every cycle for 20 cycles, no reads -> log_count=16, log_overflow=1, popped timestamps 0..15 in order.
- Full push+pop and mid-run reset: at full, assert log_rd during a logged change -> log_count stays 16, overflow unchanged. Then assert reset in RUN -> all outputs at reset values; the next start gives an empty FIFO and overflow=0.

Source files
------------

// File: rtl/cpu_run_monitor_if.sv
// Bus between the run monitor and its host: run control, watched CPU port and
// the FWFT log FIFO read side. The monitor uses the slave modport.
interface cpu_run_monitor_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int TS_WIDTH        = 32,
    parameter int FIFO_DEPTH_BITS = 4
);
    logic                       start;
    logic                       stop;
    logic                       cpu_reset;
    logic                       running;
    logic                       done;
    logic                       timeout;
    logic [DATA_WIDTH-1:0]      watch_data;
    logic                       log_rd;
    logic                       log_valid;
    logic [DATA_WIDTH-1:0]      log_value;
    logic [TS_WIDTH-1:0]        log_time;
    logic [FIFO_DEPTH_BITS:0]   log_count;
    logic                       log_overflow;
    logic [TS_WIDTH-1:0]        tick_count;

    modport master (
        output start, stop, watch_data, log_rd,
        input  cpu_reset, running, done, timeout,
        input  log_valid, log_value, log_time, log_count, log_overflow, tick_count
    );

    modport slave (
        input  start, stop, watch_data, log_rd,
        output cpu_reset, running, done, timeout,
        output log_valid, log_value, log_time, log_count, log_overflow, tick_count
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller for sc1_cpu: sequences the CPU reset, bounds the run length and
// logs every change of the watched port with its tick timestamp into a FWFT FIFO.
module cpu_run_monitor #(
    parameter int DATA_WIDTH      = 32,
    parameter int TS_WIDTH        = 32,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int RESET_CYCLES    = 2,
    parameter int MAX_TICKS       = 4000
) (
    input  logic               clk,
    input  logic               reset,
    cpu_run_monitor_if.slave   bus
);

    localparam int                       DEPTH    = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] DEPTH_C  = (FIFO_DEPTH_BITS+1)'(DEPTH);
    localparam int                       RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0]          RC_LOAD  = RC_W'(RESET_CYCLES - 1);
    localparam logic [TS_WIDTH-1:0]      MAX_LAST = TS_WIDTH'(MAX_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    logic                       r_cpu_reset;
    logic                       r_running;
    logic                       r_done;
    logic                       r_timeout;
    logic                       r_first;
    logic [RC_W-1:0]            r_rst_cnt;
    logic [TS_WIDTH-1:0]        r_tick;
    logic [DATA_WIDTH-1:0]      r_prev;

    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    logic                       r_overflow;
    logic [DATA_WIDTH-1:0]      r_mem_value [DEPTH];
    logic [TS_WIDTH-1:0]        r_mem_time  [DEPTH];

    logic w_in_run;
    logic w_launch;
    logic w_max_hit;
    logic w_push;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_store;
    logic w_drop;

    assign w_in_run  = (r_state == S_RUN);
    assign w_launch  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_max_hit = (MAX_TICKS != 0) && (r_tick == MAX_LAST);

    // The first RUN cycle always logs so the host sees the starting value.
    assign w_push  = w_in_run && (r_first || (bus.watch_data != r_prev));
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = bus.log_rd && !w_empty;
    assign w_store = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_first     <= 1'b0;
            r_rst_cnt   <= '0;
            r_tick      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state     <= S_RESET;
                        r_rst_cnt   <= RC_LOAD;
                        r_tick      <= '0;
                        r_timeout   <= 1'b0;
                        r_done      <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == '0) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                        r_first     <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - RC_W'(1);
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    // The limit wins over stop so a coincident stop still reports timeout.
                    if (bus.stop || w_max_hit) begin
                        r_state     <= S_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_timeout   <= w_max_hit;
                    end else begin
                        r_tick <= r_tick + TS_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_BITS'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_BITS'(1);
            if (w_drop)  r_overflow <= 1'b1;
            unique case ({w_store, w_pop})
                2'b10:   r_count <= r_count + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_DEPTH_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage and the change-detect sample carry no reset; r_first masks r_prev.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_value[r_wr_ptr] <= bus.watch_data;
            r_mem_time[r_wr_ptr]  <= r_tick;
        end
        if (w_in_run) r_prev <= bus.watch_data;
    end

    assign bus.cpu_reset    = r_cpu_reset;
    assign bus.running      = r_running;
    assign bus.done         = r_done;
    assign bus.timeout      = r_timeout;
    assign bus.tick_count   = r_tick;
    assign bus.log_valid    = !w_empty;
    assign bus.log_count    = r_count;
    assign bus.log_overflow = r_overflow;
    assign bus.log_value    = w_empty ? '0 : r_mem_value[r_rd_ptr];
    assign bus.log_time     = w_empty ? '0 : r_mem_time[r_rd_ptr];

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: directed and randomized runs against a
// change-list model of the log; a negedge monitor checks every popped entry.
module tb_cpu_run_monitor;

    localparam int DW    = 32;
    localparam int TW    = 32;
    localparam int FB    = 4;
    localparam int RC    = 2;
    localparam int MT    = 20;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    cpu_run_monitor_if #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .FIFO_DEPTH_BITS(FB)) bus_if ();

    cpu_run_monitor #(
        .DATA_WIDTH(DW), .TS_WIDTH(TW), .FIFO_DEPTH_BITS(FB),
        .RESET_CYCLES(RC), .MAX_TICKS(MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] v;
        logic [TW-1:0] t;
    } entry_t;

    entry_t        exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            m_count  = 0;
    bit            m_ovf    = 1'b0;
    logic [DW-1:0] wv [MT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pop is compared with the scoreboard head.
    always @(negedge clk) begin : monitor
        entry_t e;
        if (reset === 1'b0 && bus_if.log_rd === 1'b1 && bus_if.log_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_entry: got value %0d time %0d, scoreboard empty",
                         bus_if.log_value, bus_if.log_time);
            end else begin
                e = exp_q.pop_front();
                chk("log_value", bus_if.log_value, e.v);
                chk("log_time", bus_if.log_time, e.t);
            end
        end
    end

    // Log model: a change is stored while room exists (or a pop frees a slot), else dropped.
    task automatic model_cycle(input bit push, input logic [DW-1:0] v, input int t, input bit pop);
        entry_t e;
        bit     do_pop;
        do_pop = pop && (m_count > 0);
        if (push) begin
            if (m_count < DEPTH || do_pop) begin
                e.v = v;
                e.t = t;
                exp_q.push_back(e);
                m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (do_pop) m_count--;
    endtask

    task automatic check_reset_values(input string tag);
        chkb({tag, "_cpu_reset"}, bus_if.cpu_reset, 1'b1);
        chkb({tag, "_running"}, bus_if.running, 1'b0);
        chkb({tag, "_done"}, bus_if.done, 1'b0);
        chkb({tag, "_timeout"}, bus_if.timeout, 1'b0);
        chk({tag, "_tick"}, bus_if.tick_count, 0);
        chkb({tag, "_valid"}, bus_if.log_valid, 1'b0);
        chk({tag, "_count"}, 32'(bus_if.log_count), 0);
        chkb({tag, "_ovf"}, bus_if.log_overflow, 1'b0);
        chk({tag, "_value"}, bus_if.log_value, 0);
        chk({tag, "_time"}, bus_if.log_time, 0);
    endtask

    task automatic do_run(input int stop_tick, input int rd_tick, input int poke_tick, input int rst_tick);
        int last;
        bit chg;
        last = MT - 1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        chkb("launch_cpu_reset", bus_if.cpu_reset, 1'b1);
        chk("launch_count", 32'(bus_if.log_count), 0);
        chkb("launch_ovf", bus_if.log_overflow, 1'b0);
        chkb("launch_timeout", bus_if.timeout, 1'b0);
        chk("launch_tick", bus_if.tick_count, 0);
        tick();
        chkb("rst2_cpu_reset", bus_if.cpu_reset, 1'b1);
        chkb("rst2_running", bus_if.running, 1'b0);
        tick();
        chkb("run_cpu_reset", bus_if.cpu_reset, 1'b0);
        chkb("run_running", bus_if.running, 1'b1);
        for (int i = 0; i < MT; i++) begin
            chk("run_tick", bus_if.tick_count, i);
            if (i == rst_tick) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_q.delete();
                m_count = 0;
                m_ovf   = 1'b0;
                check_reset_values("midrun_reset");
                return;
            end
            if (i == 0) chg = 1'b1;
            else        chg = (wv[i] != wv[i-1]);
            bus_if.watch_data = wv[i];
            bus_if.stop       = (i == stop_tick);
            bus_if.log_rd     = (i == rd_tick);
            bus_if.start      = (i == poke_tick);
            model_cycle(chg, wv[i], i, i == rd_tick);
            tick();
            bus_if.stop   = 1'b0;
            bus_if.log_rd = 1'b0;
            bus_if.start  = 1'b0;
            chk("run_count", 32'(bus_if.log_count), m_count);
            chkb("run_ovf", bus_if.log_overflow, m_ovf);
            if (i == stop_tick || i == MT - 1) begin
                last = i;
                break;
            end
        end
        chkb("end_done", bus_if.done, 1'b1);
        chkb("end_running", bus_if.running, 1'b0);
        chkb("end_cpu_reset", bus_if.cpu_reset, 1'b1);
        chkb("end_timeout", bus_if.timeout, last == MT - 1);
        chk("end_tick", bus_if.tick_count, last);
    endtask

    task automatic drain();
        bus_if.log_rd = 1'b1;
        for (int k = 0; k < DEPTH + 4 && bus_if.log_valid === 1'b1; k++) tick();
        bus_if.log_rd = 1'b0;
        chkb("drain_empty", bus_if.log_valid, 1'b0);
        chk("drain_scoreboard_left", exp_q.size(), 0);
        m_count = 0;
    endtask

    initial begin
        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.stop       = 1'b0;
        bus_if.log_rd     = 1'b0;
        bus_if.watch_data = '0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // stop and read while idle do nothing
        bus_if.stop   = 1'b1;
        bus_if.log_rd = 1'b1;
        tick();
        bus_if.stop   = 1'b0;
        bus_if.log_rd = 1'b0;
        tick();
        check_reset_values("idle_stop");

        // change detection + timeout
        for (int i = 0; i < MT; i++) wv[i] = (i < 10) ? 32'd5 : 32'd6;
        do_run(-1, -1, -1, -1);
        chk("chg_count", 32'(bus_if.log_count), 2);
        drain();

        // early stop, start during RUN ignored
        for (int i = 0; i < MT; i++) wv[i] = $urandom_range(0, 3);
        do_run(7, -1, 4, -1);
        drain();

        // overflow: changes every cycle, no reads
        for (int i = 0; i < MT; i++) wv[i] = 32'd100 + i;
        do_run(-1, -1, -1, -1);
        chk("ovf_count", 32'(bus_if.log_count), DEPTH);
        chkb("ovf_flag", bus_if.log_overflow, 1'b1);
        drain();
        chkb("ovf_sticky", bus_if.log_overflow, 1'b1);

        // push+pop at full, then a drop, then reset mid-run
        for (int i = 0; i < MT; i++) wv[i] = 32'd200 + i;
        do_run(-1, 16, -1, 18);

        for (int i = 0; i < MT; i++) wv[i] = $urandom;
        do_run(-1, -1, -1, -1);
        drain();

        // randomized runs; sometimes left undrained so the next start must clear the log
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MT; i++) wv[i] = $urandom_range(0, 3);
            do_run($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), -1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
